// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: splits an N-bit posit into sign, regime k, exponent
// field and a hidden-one mantissa, with valid/ready flow control on both sides.
module posit_decode_pipe #(
   parameter int N  = 32,
   parameter int ES = 4,
   parameter int RS = $clog2(N)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [N-1:0]                    in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_sign,
   output logic signed [RS:0]              out_k,
   output logic [((ES > 0) ? ES : 1)-1:0]  out_exp,
   output logic [N-1:0]                    out_mant,
   output logic                            out_zero,
   output logic                            out_nar
);

   localparam int EW = (ES > 0) ? ES : 1;
   localparam int KW = RS + 1;
   localparam int MW = $clog2(N);

   // Handshake: a word moves across a boundary on the cycle where valid and
   // ready are both high there; valid never depends on ready, and a held
   // word keeps its valid and data stable until it is taken.
   logic s2_ready;

   logic          s1_valid;
   logic          s1_sign;
   logic          s1_zero;
   logic          s1_nar;
   logic [N-2:0]  s1_r;
   logic [MW-1:0] s1_m;

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;

   // Stage 1 combinational: remainder and length of its leading run
   logic [N-2:0]  r_c;
   logic [MW-1:0] m_c;
   logic          run_c;
   logic          zero_c;
   logic          nar_c;

   always_comb begin
      r_c    = in_data[N-1] ? ((N-1)'(~in_data[N-2:0]) + (N-1)'(1)) : in_data[N-2:0];
      zero_c = (in_data == '0);
      nar_c  = in_data[N-1] && (in_data[N-2:0] == '0);
      m_c    = '0;
      run_c  = 1'b1;
      for (int i = N-2; i >= 0; i--) begin
         if (run_c && (r_c[i] == r_c[N-2]))
            m_c = m_c + MW'(1);
         else
            run_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_r     <= '0;
         s1_m     <= '0;
      end else begin
         if (in_ready)
            s1_valid <= in_valid;
         if (in_valid && in_ready) begin
            s1_sign <= in_data[N-1];
            s1_zero <= zero_c;
            s1_nar  <= nar_c;
            s1_r    <= r_c;
            s1_m    <= m_c;
         end
      end
   end

   // Stage 2 combinational: regime value, shifted remainder, field split
   int                sh_c;
   logic [N-2:0]      s_c;
   logic [N-2:0]      frac_c;
   logic signed [RS:0] k_c;
   logic [EW-1:0]     exp_c;
   logic [N-1:0]      mant_c;

   always_comb begin
      sh_c   = int'(s1_m) + 1;
      s_c    = (sh_c >= N-1) ? '0 : (s1_r << sh_c);
      k_c    = s1_r[N-2] ? KW'(int'(s1_m) - 1) : KW'(-int'(s1_m));
      exp_c  = EW'(s_c >> (N-1-ES));
      frac_c = s_c << ES;
      mant_c = {1'b1, frac_c};
      // Zero and NaR carry no regime/exponent/mantissa
      if (s1_zero || s1_nar) begin
         k_c    = '0;
         exp_c  = '0;
         mant_c = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_k     <= '0;
         out_exp   <= '0;
         out_mant  <= '0;
         out_zero  <= 1'b0;
         out_nar   <= 1'b0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_sign <= s1_sign;
            out_k    <= k_c;
            out_exp  <= exp_c;
            out_mant <= mant_c;
            out_zero <= s1_zero;
            out_nar  <= s1_nar;
         end
      end
   end

endmodule

// File: doc/posit_decode_pipe.md
POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 SHALL have parameter N, default 32: posit word width, legal range 8..64.
REQ-002 SHALL have parameter ES, default 4: exponent field width, legal range 0..N-3.
REQ-003 SHALL have parameter RS, default $clog2(N): regime count width, giving a k output of RS+1 bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, N bits: posit word.
REQ-009 SHALL have port out_valid, output, 1 bit: decoded fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the decoded fields.
REQ-011 SHALL have port out_sign, output, 1 bit: sign bit of the posit.
REQ-012 SHALL have port out_k, output, RS+1 bits, signed: regime value.
REQ-013 SHALL have port out_exp, output, max(ES,1) bits: exponent field; 0 when ES=0.
REQ-014 SHALL have port out_mant, output, N bits: mantissa with the hidden 1 at the MSB.
REQ-015 SHALL have port out_zero, output, 1 bit: input was the zero posit.
REQ-016 SHALL have port out_nar, output, 1 bit: input was NaR (sign=1, all other bits 0).

Function
REQ-017 SHALL be a 2-stage pipeline, with a transfer on a side when valid&&ready on that side.
- Stage 1: sign, zero/NaR detection, two's complement of the remainder, leading-run detect.
- Stage 2: regime, shift and field extraction.
REQ-018 SHALL have a latency of exactly 2 cycles from input transfer to out_valid when out_ready is held 1.
REQ-019 SHALL sustain a throughput of 1 word per cycle.
REQ-020 SHALL compute the remainder R (N-1 bits) as:
- in_data[N-2:0] when sign=0;
- the (N-1)-bit two's complement of in_data[N-2:0] when sign=1.
REQ-021 SHALL compute m, the count of leading bits of R equal to R[N-2] (range 1..N-1), and set k as:
- k = m-1 when R[N-2]=1;
- k = -m when R[N-2]=0.
REQ-022 SHALL form S = R shifted left by m+1 and zero-filled; a shift of N-1 or more gives S=0.
REQ-023 SHALL set out_exp = S[N-2:N-1-ES].
REQ-024 SHALL set out_mant = {1'b1, S[N-ES-2:0], ES zero bits}.
REQ-025 SHALL handle zero input as: out_zero=1, out_k=0, out_sign=0, out_exp=0, out_mant=0.
REQ-026 SHALL handle NaR input as: out_nar=1, out_sign=1, out_k=0, out_exp=0, out_mant=0.
REQ-027 SHALL drive in_ready = !s1_valid || s2_ready, where s2_ready = !out_valid || out_ready.
REQ-028 SHALL advance stage 2 on s2_ready.
REQ-029 SHALL hold all out_* fields and out_valid stable while out_valid=1 and out_ready=0.
REQ-030 SHALL, when both stages are full and out_ready=0:
- deassert in_ready combinationally;
- drop or duplicate no word.
REQ-031 SHALL, on a simultaneous output transfer and input transfer with both stages full, shift both stages in the same cycle without a bubble.
REQ-032 SHALL not depend on registered data contents when in_valid=0; a stage with valid=0 holds its data registers unchanged.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously clear s1_valid and out_valid to 0.
REQ-034 SHALL, on rst_n=0, clear all data registers and out_* fields to 0.
REQ-035 SHALL, when reset asserts mid-stream, discard all in-flight words; the first out_valid after release comes from a word accepted after release.
REQ-036 SHALL drive in_ready=1 during reset and in the first cycle after release.

Verification (N=8, ES=1 unless noted)
REQ-037 SHALL cover input 0x56 with out_ready=1 -> 2 cycles later: sign=0, k=0, exp=1, mant=0xB0.
REQ-038 SHALL cover input 0xAA -> sign=1, k=0, exp=1, mant=0xB0.
REQ-039 SHALL cover the regime limits:
- 0x01 -> k=-6, exp=0, mant=0x80;
- 0x7F -> k=6, exp=0, mant=0x80.
REQ-040 SHALL cover specials:
- 0x00 -> zero=1, all other fields 0;
- 0x80 -> nar=1, sign=1, other fields 0.
REQ-041 SHALL cover backpressure:
- stimulus: a stream of 6 words at 1 per cycle, out_ready=0 for 3 cycles mid-stream;
- response: in_ready falls within 2 cycles of the stall, outputs stay stable, and all 6 results emerge in order with no loss.
REQ-042 SHALL cover reset:
- stimulus: rst_n pulsed low with 2 words in flight;
- response: out_valid=0 immediately, and no stale word emerges after release.
